// File: rtl/mux2x1.sv
// Registered 2:1 multiplexer with valid tracking, last-select memory and a
// saturating select-change counter. Optional out_parity under MUX2X1_PARITY_EN.
module mux2x1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             sel_last,
  output logic [CNT_W-1:0] sw_count
`ifdef MUX2X1_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef MUX2X1_PARITY_EN
  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  logic [WIDTH-1:0] out_d,       out_q;
  logic             out_valid_d, out_valid_q;
  logic             sel_last_d,  sel_last_q;
  logic [CNT_W-1:0] sw_count_d,  sw_count_q;
  // seen_q marks that an input has been accepted since reset, so the first
  // accept only primes sel_last and never counts as a switch.
  logic             seen_d,      seen_q;
`ifdef MUX2X1_PARITY_EN
  logic             parity_d,    parity_q;
`endif

  // Next-state logic: load on accept, otherwise hold.
  always_comb begin
    out_d       = out_q;
    out_valid_d = in_valid;
    sel_last_d  = sel_last_q;
    sw_count_d  = sw_count_q;
    seen_d      = seen_q;
`ifdef MUX2X1_PARITY_EN
    parity_d    = parity_q;
`endif
    if (in_valid) begin
      out_d      = s ? b : a;
      sel_last_d = s;
      seen_d     = 1'b1;
`ifdef MUX2X1_PARITY_EN
      parity_d   = parity_of(s ? b : a);
`endif
      if (seen_q && (s != sel_last_q) && (sw_count_q != CNT_MAX)) begin
        sw_count_d = sw_count_q + CNT_ONE;
      end else begin
        sw_count_d = sw_count_q;
      end
    end else begin
      out_d = out_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      sel_last_q  <= 1'b0;
      sw_count_q  <= {CNT_W{1'b0}};
      seen_q      <= 1'b0;
`ifdef MUX2X1_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sel_last_q  <= sel_last_d;
      sw_count_q  <= sw_count_d;
      seen_q      <= seen_d;
`ifdef MUX2X1_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sel_last  = sel_last_q;
  assign sw_count  = sw_count_q;
`ifdef MUX2X1_PARITY_EN
  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux2x1.sv
// Directed self-checking bench for mux2x1: three instances cover WIDTH=1,
// a saturating CNT_W=2 counter and an 8-bit bus (with parity when enabled).
module tb_mux2x1;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1, s, in_valid;
  logic [7:0] a8, b8;

  logic       out_a, vld_a, sel_a;
  logic [7:0] cnt_a;
  logic       out_c, vld_c, sel_c;
  logic [1:0] cnt_c;
  logic [7:0] out_b;
  logic       vld_b, sel_b;
  logic [7:0] cnt_b;
`ifdef MUX2X1_PARITY_EN
  logic       par_a, par_c, par_b;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  mux2x1 #(.WIDTH(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .s(s), .in_valid(in_valid),
    .out(out_a), .out_valid(vld_a), .sel_last(sel_a), .sw_count(cnt_a)
`ifdef MUX2X1_PARITY_EN
    , .out_parity(par_a)
`endif
  );

  mux2x1 #(.WIDTH(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .s(s), .in_valid(in_valid),
    .out(out_c), .out_valid(vld_c), .sel_last(sel_c), .sw_count(cnt_c)
`ifdef MUX2X1_PARITY_EN
    , .out_parity(par_c)
`endif
  );

  mux2x1 #(.WIDTH(8), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .s(s), .in_valid(in_valid),
    .out(out_b), .out_valid(vld_b), .sel_last(sel_b), .sw_count(cnt_b)
`ifdef MUX2X1_PARITY_EN
    , .out_parity(par_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (obs !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one input and advance to just after the next rising edge.
  task automatic drive(input logic v, input logic sv, input logic av, input logic bv);
    in_valid = v;
    s        = sv;
    a1       = av;
    b1       = bv;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] tt_exp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; s = 1'b0; a1 = 1'b0; b1 = 1'b0;
    a8 = 8'hA5; b8 = 8'h3C;
    tt_exp = 8'b1100_1010;
    @(posedge clk); #1;
    check("rst_out",  32'(out_a), 32'd0);
    check("rst_vld",  32'(vld_a), 32'd0);
    check("rst_sel",  32'(sel_a), 32'd0);
    check("rst_cnt",  32'(cnt_a), 32'd0);
    rst = 1'b0;

    // Truth table: index bits are {s,b,a}.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i[2], i[0], i[1]);
      check($sformatf("tt_out%0d", i), 32'(out_a), 32'(tt_exp[i]));
      check($sformatf("tt_vld%0d", i), 32'(vld_a), 32'd1);
    end
    check("tt_cnt", 32'(cnt_a), 32'd1);

    // Hold while in_valid is low.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("hold_load", 32'(out_a), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("hold_out%0d", i), 32'(out_a), 32'd1);
      check($sformatf("hold_vld%0d", i), 32'(vld_a), 32'd0);
      check($sformatf("hold_sel%0d", i), 32'(sel_a), 32'd0);
    end
    check("pre_rst_cnt", 32'(cnt_a), 32'd2);

    // Asynchronous reset pulse between edges.
    #2 rst = 1'b1;
    #1;
    check("arst_out", 32'(out_a), 32'd0);
    check("arst_cnt", 32'(cnt_a), 32'd0);
    check("arst_sel", 32'(sel_a), 32'd0);
    check("arst_vld", 32'(vld_a), 32'd0);
    check("arst_bus", 32'(out_b), 32'd0);
    #1 rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("arst_first_out", 32'(out_a), 32'd1);
    check("arst_first_cnt", 32'(cnt_a), 32'd0);
    check("arst_first_sel", 32'(sel_a), 32'd1);

    // Reset held over an edge discards the presented input.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_discard_out", 32'(out_a), 32'd0);
    check("rst_discard_vld", 32'(vld_a), 32'd0);
    rst = 1'b0;

    // Switch count over s = 0,1,1,0,1; first edge after reset accepts.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("first_accept", 32'(out_a), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("sw_cnt", 32'(cnt_a), 32'd3);
    check("sw_sel", 32'(sel_a), 32'd1);

    // Saturation: fresh start, then 10 toggles.
    rst = 1'b1; #1 rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, i[0], 1'b0, 1'b0);
    end
    check("sat_cnt8", 32'(cnt_a), 32'd10);
    check("sat_cnt2", 32'(cnt_c), 32'd3);

    // Bus selection and parity.
    a8 = 8'hA5; b8 = 8'h3C;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("bus_b", 32'(out_b), 32'h3C);
`ifdef MUX2X1_PARITY_EN
    check("par_3c", 32'(par_b), 32'd0);
`endif
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("bus_a", 32'(out_b), 32'hA5);
`ifdef MUX2X1_PARITY_EN
    check("par_a5", 32'(par_b), 32'd0);
`endif
    b8 = 8'h3D;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("bus_b2", 32'(out_b), 32'h3D);
`ifdef MUX2X1_PARITY_EN
    check("par_3d", 32'(par_b), 32'd1);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("bus_hold", 32'(out_b), 32'h3D);
    check("bus_vld", 32'(vld_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
